dm_bytelane: RTL and testbench

Parametrised byte-lane data memory for the single-cycle/multi-cycle MIPS core, sitting in the MEM stage between the ALU result/rt-read path and the writeback mux. It supports word, halfword and byte stores and loads with optional sign extension, a registered one-cycle read port, and a hardware clear sequencer. The sequencer zeroes the array after reset or on request, because an asynchronous reset cannot clear a RAM array directly. Every committed store is logged for trace comparison against the reference simulator.

---
 rtl/dm_pkg.sv | 39 +++
 rtl/dm_lane.sv | 19 +
 rtl/dm_bytelane.sv | 94 +++++++++
 tb/tb_dm_bytelane.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared size encodings, sequencer states and byte-lane helpers for the data memory
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {CLEAR, IDLE} state_t;

  // Replace the selected lane(s) of old with the right-justified store data
  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = old;
    if (size == SZ_BYTE) m[{lane, 3'b000} +: 8] = wd[7:0];
    else if (size == SZ_HALF) m[{lane[1], 4'b0000} +: 16] = wd[15:0];
    else m = wd;
    return m;
  endfunction

  // Pull the selected lane(s) out of a word and widen to 32 bits
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    return size == SZ_BYTE ? {{24{sx & b[7]}}, b} :
           size == SZ_HALF ? {{16{sx & h[15]}}, h} : w;
  endfunction

  // Halves need even addresses, words need 4-byte alignment, size 11 never succeeds
  function automatic logic lane_misaligned(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_BYTE ? 1'b0 :
           size == SZ_HALF ? lane[0] :
           size == SZ_WORD ? |lane : 1'b1;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// dm_lane: combinational store merge, load extract/extend and misalignment detect
module dm_lane
  import dm_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] loaded,
  output logic        misaligned
);

  assign merged     = lane_merge(old_word, wdata, size, lane);
  assign loaded     = lane_extract(old_word, size, lane, sign_ext);
  assign misaligned = lane_misaligned(size, lane);

endmodule

// File: rtl/dm_bytelane.sv
// dm_bytelane: byte-lane data memory with registered read port and clear sequencer
module dm_bytelane
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter bit LOG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] pc,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       dm [DEPTH];
  state_t            state, state_d;
  logic [ADDR_W-1:0] clr_idx, idx;
  logic [31:0]       old_word, merged, loaded;
  logic              mis, idle, do_rd, do_wr, unused;

  assign idx      = addr[ADDR_W+1:2];
  assign old_word = dm[idx];
  assign idle     = state == IDLE;
  assign busy     = !idle;
  assign do_rd    = idle && mem_rd && !mis;
  assign do_wr    = idle && mem_wr && !mis;
  assign unused   = ^{pc, addr[31:ADDR_W+2]};

  dm_lane u_lane (
    .old_word  (old_word),
    .wdata     (wdata),
    .size      (size),
    .lane      (addr[1:0]),
    .sign_ext  (sign_ext),
    .merged    (merged),
    .loaded    (loaded),
    .misaligned(mis)
  );

  // Sweep ends on the edge that clears the last index; clr only starts a sweep from IDLE
  always_comb begin
    state_d = idle ? (clr ? CLEAR : IDLE) : (&clr_idx ? IDLE : CLEAR);
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else state <= state_d;
  end

  // Clear index advances only while sweeping and rests at zero in IDLE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) clr_idx <= '0;
    else clr_idx <= idle ? '0 : clr_idx + 1'b1;
  end

  // Registered load result, valid pulse and error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= do_rd;
      err    <= idle && (mem_rd || mem_wr) && mis;
      if (do_rd) rdata <= loaded;
    end
  end

  // Single write port shared by the clear sweep and committed stores
  always_ff @(posedge clk) begin
    if (!idle) dm[clr_idx] <= '0;
    else if (do_wr) dm[idx] <= merged;
  end

  // Store trace for comparison against the reference simulator
  if (LOG_EN) begin : g_log
    always_ff @(posedge clk) begin
      if (reset && do_wr) $display("@%h: *%h <= %h", pc, addr, merged);
    end
  end

endmodule

// File: tb/tb_dm_bytelane.sv
// tb_dm_bytelane: directed vector table plus clear/reset sequences for dm_bytelane
module tb_dm_bytelane;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] a, wd, exp_rdata;
    logic        exp_rv, exp_err;
  } vec_t;

  logic        clk = 1'b0, reset, clr, mem_rd, mem_wr, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, pc, wdata, rdata;
  logic        rvalid, busy, err;
  int          n_cmp = 0, n_bad = 0;
  vec_t        tbl[$];

  always #5 clk = ~clk;

  dm_bytelane #(.ADDR_W(10), .LOG_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .clr(clr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .size(size), .sign_ext(sign_ext), .addr(addr), .pc(pc), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .err(err)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] er,
                     input logic rv, input logic e);
    vec_t t;
    t = '{rd: rd, wr: wr, sz: sz, sx: sx, a: a, wd: wd, exp_rdata: er, exp_rv: rv, exp_err: e};
    tbl.push_back(t);
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; size = sz; sign_ext = sx; addr = a; wdata = wd; pc = pc + 4;
    @(posedge clk);
    #1;
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, n, 1024);
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; size = W; sign_ext = 1'b0;
    addr = '0; pc = 32'h0040_0000; wdata = '0;
    #23;
    check("reset_busy", {31'b0, busy}, 1);
    check("reset_rdata", rdata, 0);
    check("reset_rvalid", {31'b0, rvalid}, 0);
    check("reset_err", {31'b0, err}, 0);
    @(negedge clk);
    reset = 1'b1;
    count_busy("init_sweep_edges");
    cyc(1, 0, W, 0, 32'h0000_0abc, 0);
    check("post_init_lw", rdata, 0);
    check("post_init_rvalid", {31'b0, rvalid}, 1);

    add(0, 1, W, 0, 32'h10,        32'h11223344, 32'h0,        0, 0);
    add(0, 1, B, 0, 32'h11,        32'hAA,       32'h0,        0, 0);
    add(1, 0, W, 0, 32'h10,        0,            32'h1122AA44, 1, 0);
    add(0, 0, W, 0, 32'h10,        0,            32'h1122AA44, 0, 0);
    add(1, 0, B, 1, 32'h11,        0,            32'hFFFFFFAA, 1, 0);
    add(1, 0, B, 0, 32'h11,        0,            32'h000000AA, 1, 0);
    add(0, 1, H, 0, 32'h22,        32'h1234BEEF, 32'h000000AA, 0, 0);
    add(1, 0, H, 1, 32'h22,        0,            32'hFFFFBEEF, 1, 0);
    add(1, 0, H, 0, 32'h22,        0,            32'h0000BEEF, 1, 0);
    add(1, 0, H, 1, 32'h21,        0,            32'h0000BEEF, 0, 1);
    add(1, 0, W, 0, 32'h20,        0,            32'hBEEF0000, 1, 0);
    add(0, 1, W, 0, 32'h42,        32'hDEAD,     32'hBEEF0000, 0, 1);
    add(1, 0, X, 0, 32'h40,        0,            32'hBEEF0000, 0, 1);
    add(1, 0, W, 0, 32'h40,        0,            32'h0,        1, 0);
    add(0, 1, W, 0, 32'h40,        32'h9,        32'h0,        0, 0);
    add(1, 1, W, 0, 32'h40,        32'h5,        32'h9,        1, 0);
    add(1, 0, W, 0, 32'h40,        0,            32'h5,        1, 0);
    add(0, 1, W, 0, 32'h1000,      32'hCAFEF00D, 32'h5,        0, 0);
    add(1, 0, W, 0, 32'h0,         0,            32'hCAFEF00D, 1, 0);
    add(1, 0, B, 0, 32'h3,         0,            32'h000000CA, 1, 0);
    add(1, 0, B, 1, 32'h2,         0,            32'hFFFFFFFE, 1, 0);
    add(1, 0, H, 1, 32'h0,         0,            32'hFFFFF00D, 1, 0);
    add(1, 0, H, 0, 32'h2,         0,            32'h0000CAFE, 1, 0);
    add(0, 1, H, 0, 32'h43,        32'h1,        32'h0000CAFE, 0, 1);
    add(0, 1, B, 0, 32'h43,        32'h77,       32'h0000CAFE, 0, 0);
    add(1, 0, W, 1, 32'h40,        0,            32'h77000005, 1, 0);
    add(1, 0, W, 0, 32'hFFFF_F040, 0,            32'h77000005, 1, 0);
    add(1, 0, B, 1, 32'h41,        0,            32'h00000000, 1, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].wd);
      check($sformatf("v%0d_rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("v%0d_rvalid", i), {31'b0, rvalid}, {31'b0, tbl[i].exp_rv});
      check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
    end

    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_busy", {31'b0, busy}, 1);
    begin
      int n;
      n = 0;
      while (busy === 1'b1 && n < 2000) begin
        if (n == 10) begin
          mem_wr = 1'b1; size = W; addr = 32'h10; wdata = 32'hFFFF_FFFF; clr = 1'b1;
        end
        @(posedge clk);
        #1;
        mem_wr = 1'b0; clr = 1'b0;
        n++;
        if (n == 11) check("busy_store_err", {31'b0, err}, 0);
      end
      check("clr_sweep_edges", n, 1024);
    end
    for (int w = 0; w < 1024; w++) begin
      cyc(1, 0, W, 0, 32'(w) << 2, 0);
      check($sformatf("cleared_w%0d", w), rdata, 0);
    end

    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (500) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midclr_busy", {31'b0, busy}, 1);
    check("midclr_rvalid", {31'b0, rvalid}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    count_busy("reset_sweep_edges");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
